pipe_stage_skid: RTL and testbench

Parametrised, elastic pipeline stage register for the pipelined RISC-V core, generalising the fixed MEM/WB register into a reusable stage boundary. Carries a data payload plus a control field (register-file write enable, write-back source select, etc.) across a valid/ready handshake with a two-entry skid buffer. Also supports synchronous flush that kills in-flight control. It drops in at IF/ID, ID/EX, EX/MEM and MEM/WB, so hazard logic can stall or squash any stage without combinational ready paths crossing the boundary.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/pipe_stage_slot.sv | 57 +++++
 rtl/pipe_stage_skid.sv | 198 +++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stage register:
//   - pipe_state_e : occupancy state of a stage (EMPTY / ONE / FULL)
//   - default payload/control widths for each core stage boundary
//   - saturating increment helper used by the optional statistics counters
// Optional feature macro used by users of this package: PIPE_STAGE_STATS_EN.
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // IF/ID: pc 32 + instruction 32; ctrl: valid-instruction marker
    localparam int IF_ID_DATA_W  = 64;
    localparam int IF_ID_CTRL_W  = 1;
    // ID/EX: pc 32 + rs1 32 + rs2 32 + imm 32 + rd 5; ctrl: alu op, mem, wb
    localparam int ID_EX_DATA_W  = 133;
    localparam int ID_EX_CTRL_W  = 10;
    // EX/MEM: pcInc 32 + ALURes 32 + store data 32 + rd 5; ctrl: mem wr/rd + wb
    localparam int EX_MEM_DATA_W = 101;
    localparam int EX_MEM_CTRL_W = 5;
    // MEM/WB: pcInc 32 + ALURes 32 + DMDataRd 32 + rd 5; ctrl: RUWr + RUDataWrSrc
    localparam int MEM_WB_DATA_W = 101;
    localparam int MEM_WB_CTRL_W = 3;

    localparam int          STAT_W   = 32;
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        if (v == STAT_MAX) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// -----------------------------------------------------------------------------
// pipe_stage_slot
// One storage slot of the stage: a load-enabled payload register plus a
// control register that can be cleared independently so a squashed or drained
// slot never carries live control.
// Ports:
//   clk, rst_n          clock, async active-low reset (both fields to 0)
//   load                capture d_data/d_ctrl this edge
//   clr_ctrl            zero the control field this edge (wins over load)
//   d_data, d_ctrl      next payload / control
//   q_data, q_ctrl      registered payload / control
// -----------------------------------------------------------------------------
module pipe_stage_slot #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic [DATA_W-1:0] data_r;
    logic [CTRL_W-1:0] ctrl_r;

    // Payload register: only the load strobe changes it, clears are not needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {DATA_W{1'b0}};
        end else if (load) begin
            data_r <= d_data;
        end else begin
            data_r <= data_r;
        end
    end

    // Control register: clear has priority so a flush always kills control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (clr_ctrl) begin
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (load) begin
            ctrl_r <= d_ctrl;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    assign q_data = data_r;
    assign q_ctrl = ctrl_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Elastic pipeline stage register with a two-entry skid buffer (main + skid).
// in_ready and out_valid are decoded from the registered state only, so no
// combinational path crosses the stage boundary. Outputs come from the main
// slot; its control field is cleared whenever the stage goes empty, so
// out_ctrl is 0 on every bubble.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   flush                         synchronous squash of all held beats
//   in_valid/in_ready/in_data/in_ctrl     upstream handshake + beat
//   out_valid/out_ready/out_data/out_ctrl downstream handshake + beat
//   stat_bubble_cnt, stat_stall_cnt       saturating statistics counters,
//                                         present only with PIPE_STAGE_STATS_EN
// -----------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEM_WB_DATA_W,
    parameter int CTRL_W = MEM_WB_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stat_bubble_cnt,
    output logic [31:0]       stat_stall_cnt
`endif
);

    pipe_state_e       state_r;
    pipe_state_e       state_nx_s;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              accept_s;
    logic              fire_s;
    logic              main_load_s;
    logic              main_clr_s;
    logic              main_sel_skid_s;
    logic              skid_load_s;
    logic              skid_clr_s;
    logic [DATA_W-1:0] main_d_data_s;
    logic [CTRL_W-1:0] main_d_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;
    logic [CTRL_W-1:0] skid_ctrl_s;

    assign in_ready_s  = (state_r != ST_FULL);
    assign out_valid_s = (state_r != ST_EMPTY);
    assign accept_s    = in_valid & in_ready_s;
    assign fire_s      = out_valid_s & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state and slot strobes; flush overrides any accept or fire.
    always_comb begin
        state_nx_s      = state_r;
        main_load_s     = 1'b0;
        main_clr_s      = 1'b0;
        main_sel_skid_s = 1'b0;
        skid_load_s     = 1'b0;
        skid_clr_s      = 1'b0;
        if (flush) begin
            state_nx_s = ST_EMPTY;
            main_clr_s = 1'b1;
            skid_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_load_s = 1'b1;
                        state_nx_s  = ST_ONE;
                    end else begin
                        state_nx_s  = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && fire_s) begin
                        main_load_s = 1'b1;
                        state_nx_s  = ST_ONE;
                    end else if (accept_s) begin
                        skid_load_s = 1'b1;
                        state_nx_s  = ST_FULL;
                    end else if (fire_s) begin
                        // Going empty: drop the stale control so bubbles read 0.
                        main_clr_s  = 1'b1;
                        state_nx_s  = ST_EMPTY;
                    end else begin
                        state_nx_s  = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (fire_s) begin
                        main_load_s     = 1'b1;
                        main_sel_skid_s = 1'b1;
                        state_nx_s      = ST_ONE;
                    end else begin
                        state_nx_s      = ST_FULL;
                    end
                end
                default: begin
                    state_nx_s = ST_EMPTY;
                    main_clr_s = 1'b1;
                    skid_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Main slot source: the skid entry when draining FULL, else upstream.
    always_comb begin
        main_d_data_s = in_data;
        main_d_ctrl_s = in_ctrl;
        if (main_sel_skid_s) begin
            main_d_data_s = skid_data_s;
            main_d_ctrl_s = skid_ctrl_s;
        end else begin
            main_d_data_s = in_data;
            main_d_ctrl_s = in_ctrl;
        end
    end

    pipe_stage_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (main_load_s),
        .clr_ctrl (main_clr_s),
        .d_data   (main_d_data_s),
        .d_ctrl   (main_d_ctrl_s),
        .q_data   (out_data),
        .q_ctrl   (out_ctrl)
    );

    pipe_stage_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load_s),
        .clr_ctrl (skid_clr_s),
        .d_data   (in_data),
        .d_ctrl   (in_ctrl),
        .q_data   (skid_data_s),
        .q_ctrl   (skid_ctrl_s)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] stall_cnt_r;

    // Statistics: bubbles and downstream stalls; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= 32'd0;
            stall_cnt_r  <= 32'd0;
        end else begin
            if (!out_valid_s) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
            if (out_valid_s && !out_ready) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign stat_bubble_cnt = bubble_cnt_r;
    assign stat_stall_cnt  = stall_cnt_r;
`else
    // Statistics disabled: no counters and no stat ports.
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
// Scoreboard bench for pipe_stage_skid. The driver issues one set of inputs per
// cycle shortly after the rising edge and pushes every beat the stage should
// accept into exp_q. A monitor on the falling edge compares the stage outputs
// against the front of exp_q, pops it on every handshake and empties it on a
// flush. Statistics ports are checked when PIPE_STAGE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = MEM_WB_DATA_W;
    localparam int CW = MEM_WB_CTRL_W;

    typedef logic [DW+CW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]   stat_bubble_cnt;
    logic [31:0]   stat_stall_cnt;
    logic [31:0]   bub_m = 32'd0;
    logic [31:0]   stl_m = 32'd0;
`endif

    beat_t exp_q[$];
    logic  exp_valid = 1'b0;
    logic  exp_ready = 1'b1;
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W (DW),
        .CTRL_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stat_bubble_cnt (stat_bubble_cnt),
        .stat_stall_cnt  (stat_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // One cycle of stimulus. The stage holds exp_q.size() beats right now.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl, output logic acc);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        exp_valid = (exp_q.size() > 0);
        exp_ready = (exp_q.size() < 2);
        acc       = v && exp_ready && !fl;
        if (acc) begin
            exp_q.push_back({c, d});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_in_ready"},  128'(in_ready),  128'(1));
        chk({tag, "_out_data"},  128'(out_data),  128'(0));
        chk({tag, "_out_ctrl"},  128'(out_ctrl),  128'(0));
`ifdef PIPE_STAGE_STATS_EN
        chk({tag, "_bubble"},    128'(stat_bubble_cnt), 128'(0));
        chk({tag, "_stall"},     128'(stat_stall_cnt),  128'(0));
`endif
    endtask

    // Assert reset between edges and look at the outputs before any clock.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        exp_q.delete();
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        #1;
        check_reset_outputs("midreset");
    endtask

    // Monitor: compare, then retire the beat on handshake, drop all on flush.
    always @(negedge clk) begin
`ifdef PIPE_STAGE_STATS_EN
        if (!rst_n) begin
            bub_m = 32'd0;
            stl_m = 32'd0;
        end
`endif
        chk("in_ready",  128'(in_ready),  128'(exp_ready));
        chk("out_valid", 128'(out_valid), 128'(exp_valid));
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_nonempty", 128'(0), 128'(1));
            end else begin
                chk("out_beat", 128'({out_ctrl, out_data}), 128'(exp_q[0]));
            end
        end else begin
            chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
        end
`ifdef PIPE_STAGE_STATS_EN
        chk("stat_bubble", 128'(stat_bubble_cnt), 128'(bub_m));
        chk("stat_stall",  128'(stat_stall_cnt),  128'(stl_m));
`endif
        if (rst_n) begin
            if (exp_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (flush) begin
                exp_q.delete();
            end
`ifdef PIPE_STAGE_STATS_EN
            if (!exp_valid && bub_m != 32'hFFFF_FFFF) bub_m = bub_m + 32'd1;
            if (exp_valid && !out_ready && stl_m != 32'hFFFF_FFFF) stl_m = stl_m + 32'd1;
`endif
        end
    end

    initial begin
        logic          acc;
        logic          pv;
        logic          fl;
        logic          ordy;
        logic [DW-1:0] pd;
        logic [CW-1:0] pc;
        int            k;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs("reset");

        // First beat right after reset release, then idle.
        step(1'b1, DW'(32'h0A), 3'b101, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Full-rate stream 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, acc);
            chk("stream_accept", 128'(acc), 128'(1));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Idle then stall: fill main+skid with out_ready low, 0x03 waits upstream.
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        k = 1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, DW'(k), 3'b010, 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_next_pending", 128'(k), 128'(3));
        // Release downstream; 0x03 stays offered until the stage takes it.
        for (int i = 0; i < 6; i++) begin
            if (k <= 3) begin
                step(1'b1, DW'(k), 3'b010, 1'b1, 1'b0, acc);
                if (acc) k++;
            end else begin
                step(1'b0, '0, '0, 1'b1, 1'b0, acc);
            end
        end
        chk("bp_all_sent", 128'(k), 128'(4));

        // Flush while FULL with 0x44 offered.
        step(1'b1, DW'(32'h11), 3'b011, 1'b0, 1'b0, acc);
        step(1'b1, DW'(32'h22), 3'b110, 1'b0, 1'b0, acc);
        step(1'b1, DW'(32'h44), 3'b111, 1'b0, 1'b1, acc);
        chk("flush_drop", 128'(acc), 128'(0));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        end

        // Asynchronous reset with both slots occupied, then restart.
        step(1'b1, DW'(32'h55), 3'b001, 1'b0, 1'b0, acc);
        step(1'b1, DW'(32'h66), 3'b100, 1'b0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, DW'(32'h70 + i), CW'(i + 1), 1'b1, 1'b0, acc);
        end

        // Randomised traffic; upstream keeps a beat stable until taken or flushed.
        pv = 1'b0;
        pd = '0;
        pc = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!pv && $urandom_range(0, 3) != 0) begin
                pv = 1'b1;
                pd = rnd_data();
                pc = CW'($urandom);
            end
            fl   = ($urandom_range(0, 31) == 0);
            ordy = ($urandom_range(0, 9) < 7);
            step(pv, pd, pc, ordy, fl, acc);
            if (acc || fl) pv = 1'b0;
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        end
        @(negedge clk);
        #1;
        chk("drained", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
